// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Moore sequencer for a multi-cycle MIPS-subset datapath (R-type, lw, sw,
// bne, xori, j). One ALU and one unified memory port are shared across the
// FETCH / DECODE / EXEC / MEM / WB steps. Illegal opcodes and memory stalls
// longer than MEM_WAIT_MAX cycles park the FSM in a sticky TRAP state.
//
// Optional feature macro: MC_CTRL_PERF_EN
//   defined   -> adds instr_retired / cycle_count perf counters (CNT_W wide)
//   undefined -> counters and their ports are absent
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   opcode[5:0]         IR[31:26], valid from DECODE onward
//   alu_zero            ALU zero flag (bne decision)
//   mem_ready           memory handshake done
//   mem_req, mem_we     memory request / write select
//   iord                address select (0 PC, 1 ALUOut)
//   ir_write, pc_write  IR / PC load enables
//   pc_src[1:0]         PC source select
//   alu_src_a, alu_src_b[1:0], alu_op[1:0], sign_zero   ALU controls
//   reg_write, reg_dst, mem_to_reg                      register file controls
//   trap                sticky error flag
//   state_o[3:0]        current state (debug)
//   instr_retired, cycle_count  (MC_CTRL_PERF_EN only)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 15
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W        = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             sign_zero,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [3:0]       state_o
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] cycle_count
`endif
);

  localparam int unsigned WD_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_MEM = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_EXEC_I = 4'd8,
    S_WB_I   = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WD_W-1:0]   r_wd_cnt;
  logic              w_wd_hit;
  logic              w_in_wait;

  // Watchdog limit reached on the current stalled cycle (disabled when MAX = 0)
  assign w_wd_hit  = (MEM_WAIT_MAX != 0) && (r_wd_cnt == WD_W'(MEM_WAIT_MAX));
  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  // Consecutive-stall counter; clears on mem_ready or on leaving the wait state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if ((MEM_WAIT_MAX != 0) && w_in_wait && !mem_ready && (w_state_next == r_state)) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // Next-state and Moore output decode; everything is held at 0 during reset
  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    sign_zero    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    trap         = 1'b0;
    state_o      = 4'd0;

    if (rst_n) begin
      state_o = r_state;
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          // mem_ready takes priority over a simultaneous timeout
          if (mem_ready)     w_state_next = S_DECODE;
          else if (w_wd_hit) w_state_next = S_TRAP;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE:     w_state_next = S_EXEC_R;
            OP_LW, OP_SW: w_state_next = S_ADDR;
            OP_BNE:       w_state_next = S_BRANCH;
            OP_XORI:      w_state_next = S_EXEC_I;
            OP_J:         w_state_next = S_JUMP;
            default:      w_state_next = S_TRAP;
          endcase
        end
        S_ADDR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          w_state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready)     w_state_next = S_WB_MEM;
          else if (w_wd_hit) w_state_next = S_TRAP;
        end
        S_WB_MEM: begin
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
          w_state_next = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
          if (mem_ready)     w_state_next = S_FETCH;
          else if (w_wd_hit) w_state_next = S_TRAP;
        end
        S_EXEC_R: begin
          alu_src_a    = 1'b1;
          alu_op       = 2'b10;
          w_state_next = S_WB_R;
        end
        S_WB_R: begin
          reg_write    = 1'b1;
          reg_dst      = 1'b1;
          w_state_next = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          alu_op       = 2'b11;
          sign_zero    = 1'b1;
          w_state_next = S_WB_I;
        end
        S_WB_I: begin
          reg_write    = 1'b1;
          w_state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a    = 1'b1;
          alu_op       = 2'b01;
          pc_src       = 2'b01;
          pc_write     = ~alu_zero;
          w_state_next = S_FETCH;
        end
        S_JUMP: begin
          pc_src       = 2'b10;
          pc_write     = 1'b1;
          w_state_next = S_FETCH;
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          w_state_next = S_TRAP;
        end
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] r_instr_retired;
  logic [CNT_W-1:0] r_cycle_count;

  // Retirement = any return to FETCH from another state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr_retired <= '0;
      r_cycle_count   <= '0;
    end else begin
      if ((r_state != S_FETCH) && (w_state_next == S_FETCH))
        r_instr_retired <= r_instr_retired + CNT_W'(1);
      if (r_state != S_TRAP)
        r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  assign instr_retired = rst_n ? r_instr_retired : '0;
  assign cycle_count   = rst_n ? r_cycle_count   : '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        sign_zero, reg_write, reg_dst, mem_to_reg, trap;
  logic [3:0]  state_o;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_retired, cycle_count;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_WAIT_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .sign_zero  (sign_zero),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .trap       (trap),
    .state_o    (state_o)
`ifdef MC_CTRL_PERF_EN
    ,
    .instr_retired (instr_retired),
    .cycle_count   (cycle_count)
`endif
  );

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
  //  alu_op, sign_zero, reg_write, reg_dst, mem_to_reg, trap}
  logic [16:0] w_out;
  assign w_out = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, sign_zero, reg_write, reg_dst, mem_to_reg, trap};

  //                                mr    we    io    irw   pcw   pcs    a     b      op     sz    rw    rd    m2r   tr
  localparam logic [16:0] E_ZERO = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_FW   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_FR   = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_DEC  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_ADDR = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_MRD  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_WBM  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [16:0] E_MWR  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_EXR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_WBR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [16:0] E_EXI  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_WBI  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_BRT  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_BRN  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_JMP  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] E_TRAP = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic        az;
    logic [3:0]  st;
    logic [16:0] out;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic az,
                     input logic [3:0] st, input logic [16:0] out);
    vec_t v;
    v.rst_n = r; v.op = op; v.rdy = rdy; v.az = az; v.st = st; v.out = out;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic rdy, input logic az);
    rst_n = r; opcode = op; mem_ready = rdy; alu_zero = az;
  endtask

  // Let combinational outputs settle, then compare state and output vector
  task automatic check(input string tag, input logic [3:0] st, input logic [16:0] out);
    #2;
    chk({tag, "/state"}, 32'(state_o), 32'(st));
    chk({tag, "/outs"},  32'(w_out),   32'(out));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, OP_R, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    drive(1'b0, OP_R, 1'b0, 1'b0);

    // reset: outputs held 0 even with mem_ready asserted
    add(0, OP_R, 0, 0, 4'd0, E_ZERO);
    add(0, OP_R, 1, 0, 4'd0, E_ZERO);
    // R-type, zero wait: 0,1,6,7
    add(1, OP_R, 1, 0, 4'd0,  E_FR);
    add(1, OP_R, 0, 0, 4'd1,  E_DEC);
    add(1, OP_R, 0, 0, 4'd6,  E_EXR);
    add(1, OP_R, 0, 0, 4'd7,  E_WBR);
    // lw with 3 wait cycles in MEM_RD: 8 cycles
    add(1, OP_LW, 1, 0, 4'd0, E_FR);
    add(1, OP_LW, 0, 0, 4'd1, E_DEC);
    add(1, OP_LW, 0, 0, 4'd2, E_ADDR);
    add(1, OP_LW, 0, 0, 4'd3, E_MRD);
    add(1, OP_LW, 0, 0, 4'd3, E_MRD);
    add(1, OP_LW, 0, 0, 4'd3, E_MRD);
    add(1, OP_LW, 1, 0, 4'd3, E_MRD);
    add(1, OP_LW, 0, 0, 4'd4, E_WBM);
    // sw with one fetch wait
    add(1, OP_SW, 0, 0, 4'd0, E_FW);
    add(1, OP_SW, 1, 0, 4'd0, E_FR);
    add(1, OP_SW, 0, 0, 4'd1, E_DEC);
    add(1, OP_SW, 0, 0, 4'd2, E_ADDR);
    add(1, OP_SW, 0, 0, 4'd5, E_MWR);
    add(1, OP_SW, 1, 0, 4'd5, E_MWR);
    // bne taken (alu_zero=0)
    add(1, OP_BNE, 1, 1, 4'd0,  E_FR);
    add(1, OP_BNE, 0, 1, 4'd1,  E_DEC);
    add(1, OP_BNE, 0, 0, 4'd10, E_BRT);
    // bne not taken (alu_zero=1)
    add(1, OP_BNE, 1, 0, 4'd0,  E_FR);
    add(1, OP_BNE, 0, 0, 4'd1,  E_DEC);
    add(1, OP_BNE, 0, 1, 4'd10, E_BRN);
    // xori; stray mem_ready in DECODE has no effect
    add(1, OP_XORI, 1, 0, 4'd0, E_FR);
    add(1, OP_XORI, 1, 0, 4'd1, E_DEC);
    add(1, OP_XORI, 0, 0, 4'd8, E_EXI);
    add(1, OP_XORI, 0, 0, 4'd9, E_WBI);
    // j
    add(1, OP_J, 1, 0, 4'd0,  E_FR);
    add(1, OP_J, 0, 0, 4'd1,  E_DEC);
    add(1, OP_J, 0, 0, 4'd11, E_JMP);
    // illegal opcode
    add(1, OP_BAD, 1, 0, 4'd0,  E_FR);
    add(1, OP_BAD, 0, 0, 4'd1,  E_DEC);
    add(1, OP_BAD, 1, 0, 4'd12, E_TRAP);

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].op, tbl[i].rdy, tbl[i].az);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].out);
      tick();
    end

    // TRAP is sticky for 20 cycles regardless of inputs
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check($sformatf("trap_hold%0d", i), 4'd12, E_TRAP);
      tick();
    end
    drive(1'b0, OP_R, 1'b0, 1'b0);
    check("trap_rst", 4'd0, E_ZERO);
    tick();
    drive(1'b1, OP_R, 1'b0, 1'b0);
    check("trap_release", 4'd0, E_FW);

    // Fetch watchdog (MEM_WAIT_MAX=4): TRAP 5 cycles after FETCH entry
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_R, 1'b0, 1'b0);
      check($sformatf("wd_fetch%0d", i), 4'd0, E_FW);
      tick();
    end
    check("wd_fetch_trap", 4'd12, E_TRAP);

    // mem_ready on the timeout cycle wins
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_LW, 1'b0, 1'b0);
      check($sformatf("wd_win%0d", i), 4'd0, E_FW);
      tick();
    end
    drive(1'b1, OP_LW, 1'b1, 1'b0);
    check("wd_win_ready", 4'd0, E_FR);
    tick();
    drive(1'b1, OP_LW, 1'b0, 1'b0);
    check("wd_win_dec", 4'd1, E_DEC);
    tick();
    check("wd_rd_addr", 4'd2, E_ADDR);
    tick();
    // MEM_RD watchdog
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wd_rd%0d", i), 4'd3, E_MRD);
      tick();
    end
    check("wd_rd_trap", 4'd12, E_TRAP);

    // Reset in the middle of a store drops mem_req and abandons the access
    do_reset();
    drive(1'b1, OP_SW, 1'b1, 1'b0);
    tick();
    drive(1'b1, OP_SW, 1'b0, 1'b0);
    tick();
    tick();
    check("abort_memwr", 4'd5, E_MWR);
    drive(1'b0, OP_SW, 1'b0, 1'b0);
    check("abort_rst", 4'd0, E_ZERO);
    tick();
    drive(1'b1, OP_SW, 1'b0, 1'b0);
    check("abort_refetch", 4'd0, E_FW);

`ifdef MC_CTRL_PERF_EN
    // Three jumps: 9 cycles, 3 retirements
    do_reset();
    drive(1'b1, OP_J, 1'b1, 1'b0);
    #2;
    chk("perf_rst_ret", instr_retired, 32'd0);
    chk("perf_rst_cyc", cycle_count, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, OP_J, 1'b1, 1'b0);
      check($sformatf("perf_f%0d", k), 4'd0, E_FR);
      tick();
      drive(1'b1, OP_J, 1'b0, 1'b0);
      check($sformatf("perf_d%0d", k), 4'd1, E_DEC);
      tick();
      check($sformatf("perf_j%0d", k), 4'd11, E_JMP);
      tick();
    end
    #2;
    chk("perf_ret", instr_retired, 32'd3);
    chk("perf_cyc", cycle_count, 32'd9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
